// File: rtl/bcd_conv_seq.sv
// rtl/bcd_conv_seq.sv - sequential shift-add-3 binary to packed BCD converter
// Optional macro BCD_CONV_BACK_TO_BACK_EN: accept a new value in DONE on the same edge as the output handoff.
module bcd_conv_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_digits_too_small
    $fatal(1, "bcd_conv_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  bin_reg;
  logic [BW-1:0]     bcd_acc;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [BW-1:0]     out_bcd_r;
  logic [CW-1:0]     cnt;
  logic              accept;

  assign accept  = in_valid && in_ready;
  assign out_bcd = out_bcd_r;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
      S_DONE: begin
        if (accept) state_nxt = S_SHIFT;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
`ifdef BCD_CONV_BACK_TO_BACK_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Each digit is corrected independently; no carry crosses a digit boundary.
  always_comb begin
    adj = bcd_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
    end
    shifted = (adj << 1) | {{(BW-1){1'b0}}, bin_reg[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      bin_reg   <= '0;
      bcd_acc   <= '0;
      cnt       <= '0;
      out_bcd_r <= '0;
    end else if (accept) begin
      bin_reg <= in_data;
      bcd_acc <= '0;
      cnt     <= CW'(WIDTH);
    end else if (state == S_SHIFT) begin
      bcd_acc <= shifted;
      bin_reg <= bin_reg << 1;
      cnt     <= cnt - CW'(1);
      if (cnt == CW'(1)) out_bcd_r <= shifted;
    end
  end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// tb/tb_bcd_conv_seq.sv - self-checking bench for bcd_conv_seq
module tb_bcd_conv_seq;

  logic       clk;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_bcd;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

`ifdef BCD_CONV_BACK_TO_BACK_EN
  localparam int PERIOD = 6;
`else
  localparam int PERIOD = 7;
`endif

  typedef struct {
    logic [4:0] din;
    logic [7:0] exp;
  } vec_t;

  bcd_conv_seq #(.WIDTH(5), .DIGITS(2)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decimal digits by plain division, independent of the shift-add-3 method.
  function automatic logic [7:0] ref_bcd(input int v);
    logic [7:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 2; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic do_convert(input logic [4:0] v, output logic [7:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    res = out_bcd;
    tick();
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] res;
    int         lat;
    logic [4:0] v;
    logic [4:0] svals[5];
    logic [4:0] q[$];
    int         sent, got, cyc, last;

    total = 0;
    bad   = 0;
    vecs[0] = '{5'd0,  8'h00};
    vecs[1] = '{5'd9,  8'h09};
    vecs[2] = '{5'd10, 8'h10};
    vecs[3] = '{5'd19, 8'h19};
    vecs[4] = '{5'd20, 8'h20};
    vecs[5] = '{5'd31, 8'h31};
    vecs[6] = '{5'd27, 8'h27};
    vecs[7] = '{5'd15, 8'h15};

    clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);

    // Single conversion of 31 with latency and busy window.
    clear = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 5'd31;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("t1_nvalid_%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_bcd", 32'(out_bcd), 32'h31);
    tick();
    check("t1_handoff", 32'(out_valid), 32'd0);
    check("t1_idle_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_convert(vecs[i].din, res, lat);
      check($sformatf("vec_%0d_bcd", vecs[i].din), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec_%0d_lat", vecs[i].din), 32'(lat), 32'd5);
    end

    for (int i = 0; i < 32; i++) begin
      do_convert(5'(i), res, lat);
      check($sformatf("sweep_%0d", i), 32'(res), 32'(ref_bcd(i)));
    end

    for (int i = 0; i < 12; i++) begin
      v = 5'($urandom_range(0, 31));
      do_convert(v, res, lat);
      check($sformatf("rand_%0d", v), 32'(res), 32'(ref_bcd(int'(v))));
    end

    // Hold output with out_ready low; competing input must be ignored.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'd27;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("t3_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 5'd5;
      check($sformatf("t3_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t3_bcd_%0d", i), 32'(out_bcd), 32'h27);
      check($sformatf("t3_nready_%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t3_valid_pre", 32'(out_valid), 32'd1);
    tick();
    check("t3_after_valid", 32'(out_valid), 32'd0);
    check("t3_after_ready", 32'(in_ready), 32'd1);
    tick();
    check("t3_no_restart", 32'(busy), 32'd0);
    check("t3_no_second", 32'(out_valid), 32'd0);

    // Reset during the third shift cycle of 22.
    in_valid = 1'b1; in_data = 5'd22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_bcd", 32'(out_bcd), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    do_convert(5'd22, res, lat);
    check("t4_redo", 32'(res), 32'h22);

    // in_data changes right after accept.
    in_valid = 1'b1; in_data = 5'd13;
    tick();
    in_valid = 1'b0; in_data = 5'd30;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("t5_bcd", 32'(out_bcd), 32'h13);
    tick();

    // Streaming with in_valid and out_ready held high.
    for (int i = 0; i < 5; i++) svals[i] = 5'($urandom_range(0, 31));
    sent = 0; got = 0; cyc = 0; last = 0;
    in_valid = 1'b1; in_data = svals[0];
    while (got < 5 && cyc < 200) begin
      if (out_valid) begin
        check($sformatf("t6_bcd_%0d", got), 32'(out_bcd), 32'(ref_bcd(int'(q.pop_front()))));
        if (got > 0) check($sformatf("t6_gap_%0d", got), 32'(cyc - last), 32'(PERIOD));
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      tick();
      cyc++;
      if (sent < 5) in_data = svals[sent];
      else in_valid = 1'b0;
    end
    check("t6_count", 32'(got), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
